// File: rtl/npu_input_fifo.sv
// Multi-lane first-word-fall-through staging FIFO for the NPU operand path.
// Valid/ready on both sides, lane-broadcast writes, synchronous flush and sticky overflow.
module npu_input_fifo #(
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLKEXT,
  input  logic                       CLR_BUF_IN,
  input  logic                       FLUSH,
  input  logic                       EN_BUF_IN,
  input  logic                       BCAST,
  input  logic [LANES*DW-1:0]        D,
  output logic                       WR_READY,
  output logic [LANES*DW-1:0]        Q,
  output logic                       RD_VALID,
  input  logic                       RD_READY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [LANES*DW-1:0] mem_reg [DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic                ovf_reg;

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [LANES*DW-1:0] wr_data;

  // Broadcast replicates lane 0 into every lane of the stored vector.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign wr_data[gi*DW +: DW] = BCAST ? D[DW-1:0] : D[gi*DW +: DW];
  end

  // Handshake flags come from registered occupancy only, so the two sides never couple combinationally.
  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);
  assign push  = EN_BUF_IN & ~full;
  assign pop   = ~empty & RD_READY;

  always_ff @(posedge CLKEXT or negedge CLR_BUF_IN) begin
    if (!CLR_BUF_IN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (FLUSH) begin
      // Storage is left alone; EMPTY gates Q to zero anyway.
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= wr_data;
        wr_ptr_reg          <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (EN_BUF_IN && full) begin
        ovf_reg <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign Q        = empty ? '0 : mem_reg[rd_ptr_reg];
  assign WR_READY = ~full;
  assign RD_VALID = ~empty;
  assign COUNT    = count_reg;
  assign FULL     = full;
  assign EMPTY    = empty;
  assign OVF      = ovf_reg;

endmodule

// File: tb/tb_npu_input_fifo.sv
// Directed bench for npu_input_fifo at DW=8, LANES=4, DEPTH=4 with hand-computed expectations.
`timescale 1ns/1ps
module tb_npu_input_fifo;

  logic        CLKEXT = 1'b0;
  logic        CLR_BUF_IN;
  logic        FLUSH;
  logic        EN_BUF_IN;
  logic        BCAST;
  logic [31:0] D;
  logic        WR_READY;
  logic [31:0] Q;
  logic        RD_VALID;
  logic        RD_READY;
  logic [2:0]  COUNT;
  logic        FULL;
  logic        EMPTY;
  logic        OVF;

  int err_cnt = 0;
  int chk_cnt = 0;

  npu_input_fifo #(.DW(8), .LANES(4), .DEPTH(4)) dut (
    .CLKEXT    (CLKEXT),
    .CLR_BUF_IN(CLR_BUF_IN),
    .FLUSH     (FLUSH),
    .EN_BUF_IN (EN_BUF_IN),
    .BCAST     (BCAST),
    .D         (D),
    .WR_READY  (WR_READY),
    .Q         (Q),
    .RD_VALID  (RD_VALID),
    .RD_READY  (RD_READY),
    .COUNT     (COUNT),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .OVF       (OVF)
  );

  always #5 CLKEXT = ~CLKEXT;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one edge, then settle 1ns so checks and new drives sit away from the edge.
  task automatic tick();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".Q"},        Q,        32'h0);
    chk({tag, ".COUNT"},    COUNT,    32'd0);
    chk({tag, ".EMPTY"},    EMPTY,    32'd1);
    chk({tag, ".FULL"},     FULL,     32'd0);
    chk({tag, ".WR_READY"}, WR_READY, 32'd1);
    chk({tag, ".RD_VALID"}, RD_VALID, 32'd0);
  endtask

  initial begin
    CLR_BUF_IN = 1'b0;
    FLUSH      = 1'b0;
    EN_BUF_IN  = 1'b0;
    BCAST      = 1'b0;
    D          = '0;
    RD_READY   = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst.OVF", OVF, 32'd0);
    CLR_BUF_IN = 1'b1;
    tick();
    chk_idle("idle");

    // Single push then pop.
    EN_BUF_IN = 1'b1; D = 32'h44332211;
    tick();
    EN_BUF_IN = 1'b0;
    chk("p1.RD_VALID", RD_VALID, 32'd1);
    chk("p1.Q",        Q,        32'h44332211);
    chk("p1.COUNT",    COUNT,    32'd1);
    RD_READY = 1'b1;
    tick();
    RD_READY = 1'b0;
    chk("p1pop.EMPTY", EMPTY, 32'd1);
    chk("p1pop.Q",     Q,     32'h0);

    // Fill, overflow, drain.
    EN_BUF_IN = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      D = 32'(i);
      tick();
    end
    chk("fill.COUNT",    COUNT,    32'd4);
    chk("fill.FULL",     FULL,     32'd1);
    chk("fill.WR_READY", WR_READY, 32'd0);
    chk("fill.OVF",      OVF,      32'd0);
    D = 32'd5;
    tick();
    EN_BUF_IN = 1'b0;
    chk("ovf.OVF",   OVF,   32'd1);
    chk("ovf.COUNT", COUNT, 32'd4);
    RD_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d.Q", i), Q, 32'(i));
      tick();
    end
    RD_READY = 1'b0;
    chk("drain.EMPTY", EMPTY, 32'd1);
    chk("drain.OVF",   OVF,   32'd1);

    // Steady push+pop at COUNT=2 across pointer wrap.
    EN_BUF_IN = 1'b1;
    D = 32'h10; tick();
    D = 32'h11; tick();
    chk("pp.COUNT0", COUNT, 32'd2);
    RD_READY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      D = 32'h12 + 32'(k);
      chk($sformatf("pp%0d.Q", k), Q, 32'h10 + 32'(k));
      tick();
      chk($sformatf("pp%0d.COUNT", k), COUNT, 32'd2);
    end
    EN_BUF_IN = 1'b0;
    chk("ppd0.Q", Q, 32'h16);
    tick();
    chk("ppd1.Q", Q, 32'h17);
    tick();
    RD_READY = 1'b0;
    chk("ppd.EMPTY", EMPTY, 32'd1);

    // Push with RD_READY on empty: push only.
    EN_BUF_IN = 1'b1; RD_READY = 1'b1; BCAST = 1'b1; D = 32'hDEADBEAB;
    tick();
    EN_BUF_IN = 1'b0; RD_READY = 1'b0; BCAST = 1'b0;
    chk("bcast.COUNT", COUNT, 32'd1);
    chk("bcast.Q",     Q,     32'hABABABAB);
    RD_READY = 1'b1;
    tick();
    RD_READY = 1'b0;

    // Fill, then push+pop while full: push refused, pop taken, OVF set.
    EN_BUF_IN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = 32'hA0 + 32'(i);
      tick();
    end
    D = 32'hAF; RD_READY = 1'b1;
    tick();
    EN_BUF_IN = 1'b0; RD_READY = 1'b0;
    chk("fpp.COUNT", COUNT, 32'd3);
    chk("fpp.OVF",   OVF,   32'd1);
    chk("fpp.Q",     Q,     32'hA1);

    // Flush overrides a same-cycle push.
    FLUSH = 1'b1; EN_BUF_IN = 1'b1; D = 32'h55;
    tick();
    FLUSH = 1'b0; EN_BUF_IN = 1'b0;
    chk_idle("flush");
    chk("flush.OVF", OVF, 32'd0);

    // Asynchronous reset mid-burst.
    EN_BUF_IN = 1'b1;
    D = 32'h61; tick();
    D = 32'h62; tick();
    chk("burst.COUNT", COUNT, 32'd2);
    #2;
    CLR_BUF_IN = 1'b0;
    #1;
    chk_idle("arst");
    EN_BUF_IN = 1'b0;
    tick();
    CLR_BUF_IN = 1'b1;
    EN_BUF_IN = 1'b1; D = 32'h77;
    tick();
    EN_BUF_IN = 1'b0;
    chk("post.COUNT", COUNT, 32'd1);
    chk("post.Q",     Q,     32'h77);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
